// File: rtl/op_shift_iter_pkg.sv
// op_shift_iter_pkg: shift-type codes, FSM states and clamp limits shared with the op_* blocks
package op_shift_iter_pkg;
  localparam logic [1:0] SH_LSL = 2'b00;
  localparam logic [1:0] SH_LSR = 2'b01;
  localparam logic [1:0] SH_ASR = 2'b10;
  localparam logic [1:0] SH_ROR = 2'b11;
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;
  localparam int SH_MAX_LSX = 33;
  localparam int SH_MAX_ASR = 32;
  localparam int CNT_W = 6;
endpackage

// File: rtl/op_shift_iter_shift_step.sv
// shift_step: one-bit LSL/LSR/ASR/ROR/RRX step producing the next word and the bit shifted out
module shift_step
  import op_shift_iter_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic [DATA_W-1:0] r,
  input  logic [1:0]        stype,
  input  logic              rrx,
  input  logic              cin,
  output logic [DATA_W-1:0] r_n,
  output logic              c_n
);
  assign c_n = (stype == SH_LSL) ? r[DATA_W-1] : r[0];
  assign r_n = rrx               ? {cin, r[DATA_W-1:1]} :
               stype == SH_LSL   ? {r[DATA_W-2:0], 1'b0} :
               stype == SH_LSR   ? {1'b0, r[DATA_W-1:1]} :
               stype == SH_ASR   ? {r[DATA_W-1], r[DATA_W-1:1]} :
                                   {r[0], r[DATA_W-1:1]};
endmodule

// File: rtl/op_shift_iter.sv
// op_shift_iter: iterative ARM operand-2 shifter, one bit per cycle under start/busy/valid
module op_shift_iter
  import op_shift_iter_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int AMT_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              amt_reg,
  input  logic [1:0]        stype,
  input  logic [4:0]        imm_shift,
  input  logic [AMT_W-1:0]  shift_amt,
  input  logic [DATA_W-1:0] Rm,
  input  logic              carry_in,
  output logic              busy,
  output logic              valid,
  output logic [DATA_W-1:0] result,
  output logic              carry_out
);
  logic [1:0]        state_q, state_d, stype_q, stype_d;
  logic [DATA_W-1:0] r_q, r_d, result_q, result_d, step_r;
  logic [CNT_W-1:0]  count_q, count_d, n, imm_n, reg_n;
  logic              c_q, c_d, rrx_q, rrx_d, cin_q, cin_d, busy_q, busy_d;
  logic              valid_q, valid_d, carry_out_q, carry_out_d, step_c;
  logic              imm_rrx, ror_wrap, c0;
  assign imm_rrx  = !amt_reg && stype == SH_ROR && imm_shift == 5'd0;
  // A nonzero register ROR that is a multiple of 32 leaves Rm intact but carries out bit 31
  assign ror_wrap = amt_reg && stype == SH_ROR && shift_amt != '0 && shift_amt[4:0] == 5'd0;
  assign c0       = ror_wrap ? Rm[DATA_W-1] : carry_in;
  assign imm_n = ((stype == SH_LSR || stype == SH_ASR) && imm_shift == 5'd0) ? CNT_W'(32) :
                 imm_rrx ? CNT_W'(1) : {1'b0, imm_shift};
  assign reg_n = stype == SH_ROR ? {1'b0, shift_amt[4:0]} :
                 stype == SH_ASR ? (shift_amt > AMT_W'(SH_MAX_ASR) ? CNT_W'(SH_MAX_ASR) : shift_amt[CNT_W-1:0]) :
                                   (shift_amt > AMT_W'(SH_MAX_LSX) ? CNT_W'(SH_MAX_LSX) : shift_amt[CNT_W-1:0]);
  assign n = amt_reg ? reg_n : imm_n;
  shift_step #(.DATA_W(DATA_W)) u_step (
    .r    (r_q),
    .stype(stype_q),
    .rrx  (rrx_q),
    .cin  (cin_q),
    .r_n  (step_r),
    .c_n  (step_c)
  );
  always_comb begin
    state_d     = state_q;
    r_d         = r_q;
    c_d         = c_q;
    stype_d     = stype_q;
    rrx_d       = rrx_q;
    cin_d       = cin_q;
    count_d     = count_q;
    busy_d      = busy_q;
    valid_d     = 1'b0;
    result_d    = result_q;
    carry_out_d = carry_out_q;
    if (state_q == ST_IDLE && start) begin
      r_d     = Rm;
      c_d     = c0;
      stype_d = stype;
      rrx_d   = imm_rrx;
      cin_d   = carry_in;
      count_d = n;
      busy_d  = 1'b1;
      state_d = n == '0 ? ST_DONE : ST_SHIFT;
    end else if (state_q == ST_SHIFT) begin
      r_d     = step_r;
      c_d     = step_c;
      count_d = count_q - 1'b1;
      state_d = count_q == CNT_W'(1) ? ST_DONE : ST_SHIFT;
    end else if (state_q == ST_DONE) begin
      valid_d     = 1'b1;
      result_d    = r_q;
      carry_out_d = c_q;
      busy_d      = 1'b0;
      state_d     = ST_IDLE;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      r_q         <= '0;
      c_q         <= 1'b0;
      stype_q     <= SH_LSL;
      rrx_q       <= 1'b0;
      cin_q       <= 1'b0;
      count_q     <= '0;
      busy_q      <= 1'b0;
      valid_q     <= 1'b0;
      result_q    <= '0;
      carry_out_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      r_q         <= r_d;
      c_q         <= c_d;
      stype_q     <= stype_d;
      rrx_q       <= rrx_d;
      cin_q       <= cin_d;
      count_q     <= count_d;
      busy_q      <= busy_d;
      valid_q     <= valid_d;
      result_q    <= result_d;
      carry_out_q <= carry_out_d;
    end
  end
  assign busy      = busy_q;
  assign valid     = valid_q;
  assign result    = result_q;
  assign carry_out = carry_out_q;
endmodule
